// File: rtl/state_pkg.sv
// Shared types and constants for the PS/2 keyboard movement controller.
// Optional feature macro: KEYBOARD_WASD_EN (the WASD alias codes live here
// unconditionally; only keyboard_move_ctl decides whether to decode them).
package state_pkg;

    // Receiver frame FSM states
    typedef enum logic [1:0] {
        IDLE_RX = 2'd0,
        DATA    = 2'd1,
        PARITY  = 2'd2,
        STOP    = 2'd3
    } Ps2State;

    // Most recently pressed direction, used to arbitrate left/right
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Scan code set 2 values
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_BRK   = 8'hF0;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_W     = 8'h1D;

    // True when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/keyboard_move_ctl_ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// FSM and a mid-frame watchdog. Emits one-cycle byte_valid / frame_err pulses.
// Optional feature macro: KEYBOARD_WASD_EN (not used in this file).
module ps2_rx
    import state_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned     WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            clk_prev_q;
    logic            fall_q;
    logic            bit_q;

    Ps2State         state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    // Two-flop synchronisers, then a registered falling-edge pulse with the data bit aligned to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value; blocking here would collapse the synchroniser chain.
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            fall_q      <= clk_prev_q & ~clk_sync_q[1];
            bit_q       <= data_sync_q[1];
        end
    end

    // Frame FSM and watchdog next-state logic
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise untaken branches infer latches.
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        wd_d         = wd_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (fall_q) begin
            wd_d = '0;
            unique case (state_q)
                IDLE_RX: begin
                    // A high bit while idle is line noise, not a start bit
                    if (!bit_q) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = bit_q;
                    state_d  = STOP;
                end
                STOP: begin
                    if (bit_q && odd_parity_ok(shift_q, parity_q)) byte_valid_d = 1'b1;
                    else                                            frame_err_d  = 1'b1;
                    state_d = IDLE_RX;
                end
                default: state_d = IDLE_RX;
            endcase
        end else if (state_q != IDLE_RX) begin
            // Watchdog runs only mid-frame and stops at its limit instead of wrapping
            if (wd_q >= WD_MAX) begin
                state_d     = IDLE_RX;
                frame_err_d = 1'b1;
                shift_d     = '0;
                wd_d        = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_RX;
            cnt_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wd_q         <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            wd_q         <= wd_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The shift register is untouched in STOP, so it still holds the byte while byte_valid is high
    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/keyboard_move_ctl.sv
// PS/2 keyboard to movement levels: decodes scan code set 2 make/break
// sequences into held bits for left, right and action, with a
// most-recent-wins rule between left and right.
// Optional feature macro: KEYBOARD_WASD_EN adds A/D/W as aliases of
// left/right/action.
module keyboard_move_ctl
    import state_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic m_left,
    output logic m_right,
    output logic button_pressed,
    output logic frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    logic ext_q, ext_d;
    logic brk_q, brk_d;
    logic held_left_q, held_left_d;
    logic held_right_q, held_right_d;
    logic held_space_q, held_space_d;
`ifdef KEYBOARD_WASD_EN
    logic held_a_q, held_a_d;
    logic held_d_q, held_d_d;
    logic held_w_q, held_w_d;
`endif
    dir_e last_dir_q, last_dir_d;
    logic m_left_q, m_left_d;
    logic m_right_q, m_right_d;
    logic button_q, button_d;
    logic dir_l_q, dir_l_d;
    logic dir_r_q, dir_r_d;
    logic make;

    // Prefix flags, held-bit updates and left/right arbitration
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        held_left_d  = held_left_q;
        held_right_d = held_right_q;
        held_space_d = held_space_q;
`ifdef KEYBOARD_WASD_EN
        held_a_d     = held_a_q;
        held_d_d     = held_d_q;
        held_w_d     = held_w_q;
`endif
        make = ~brk_q;

        if (byte_valid) begin
            if (byte_data == KEY_EXT) begin
                ext_d = 1'b1;
            end else if (byte_data == KEY_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Any other byte is a key code; it always consumes both prefixes
                if (ext_q) begin
                    if (byte_data == KEY_LEFT)  held_left_d  = make;
                    if (byte_data == KEY_RIGHT) held_right_d = make;
                end else begin
                    // Un-prefixed 6B/74 are numpad keys and fall through unmatched
                    if (byte_data == KEY_SPACE) held_space_d = make;
`ifdef KEYBOARD_WASD_EN
                    if (byte_data == KEY_A)     held_a_d     = make;
                    if (byte_data == KEY_D)     held_d_d     = make;
                    if (byte_data == KEY_W)     held_w_d     = make;
`endif
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

`ifdef KEYBOARD_WASD_EN
        dir_l_q  = held_left_q  | held_a_q;
        dir_r_q  = held_right_q | held_d_q;
        dir_l_d  = held_left_d  | held_a_d;
        dir_r_d  = held_right_d | held_d_d;
        button_d = held_space_d | held_w_d;
`else
        dir_l_q  = held_left_q;
        dir_r_q  = held_right_q;
        dir_l_d  = held_left_d;
        dir_r_d  = held_right_d;
        button_d = held_space_d;
`endif

        // Only a fresh press of a direction claims priority; repeats leave it alone
        last_dir_d = last_dir_q;
        if (dir_l_d && !dir_l_q) last_dir_d = DIR_LEFT;
        if (dir_r_d && !dir_r_q) last_dir_d = DIR_RIGHT;

        m_left_d  = dir_l_d && (!dir_r_d || last_dir_d == DIR_LEFT);
        m_right_d = dir_r_d && (!dir_l_d || last_dir_d == DIR_RIGHT);
    end

    // Decoder state and registered output levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_left_q  <= 1'b0;
            held_right_q <= 1'b0;
            held_space_q <= 1'b0;
`ifdef KEYBOARD_WASD_EN
            held_a_q     <= 1'b0;
            held_d_q     <= 1'b0;
            held_w_q     <= 1'b0;
`endif
            last_dir_q   <= DIR_LEFT;
            m_left_q     <= 1'b0;
            m_right_q    <= 1'b0;
            button_q     <= 1'b0;
        end else begin
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            held_left_q  <= held_left_d;
            held_right_q <= held_right_d;
            held_space_q <= held_space_d;
`ifdef KEYBOARD_WASD_EN
            held_a_q     <= held_a_d;
            held_d_q     <= held_d_d;
            held_w_q     <= held_w_d;
`endif
            last_dir_q   <= last_dir_d;
            m_left_q     <= m_left_d;
            m_right_q    <= m_right_d;
            button_q     <= button_d;
        end
    end

    assign m_left         = m_left_q;
    assign m_right        = m_right_q;
    assign button_pressed = button_q;

endmodule
